// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter between ALU and LSU with per-source result FIFOs
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROB_ID_W   = 5,
  parameter int DATA_W     = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear_in,
  input  logic                valid_from_alu,
  input  logic [DATA_W-1:0]   result_from_alu,
  input  logic [ROB_ID_W-1:0] rob_id_from_alu,
  input  logic                valid_from_lsu,
  input  logic [DATA_W-1:0]   result_from_lsu,
  input  logic [ROB_ID_W-1:0] rob_id_from_lsu,
  output logic                full_to_alu,
  output logic                full_to_lsu,
  output logic                cdb_valid,
  output logic [DATA_W-1:0]   cdb_result,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic                cdb_src
);

  // Source index 0 is the ALU, 1 is the LSU; an entry packs {rob_id, result}.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROB_ID_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ENT_W-1:0] mem_q [2][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr [2];
  logic [PTR_W-1:0] wr_ptr [2];
  logic [CNT_W-1:0] count [2];
  logic             last_grant;

  logic [ENT_W-1:0] in_ent   [2];
  logic [ENT_W-1:0] cand_ent [2];
  logic [ENT_W-1:0] grant_ent;
  logic [1:0]       in_valid, full, enq, has_head, cand, sel, deq, wr;
  logic             advance, do_grant, grant_src;

  assign in_ent[0] = {rob_id_from_alu, result_from_alu};
  assign in_ent[1] = {rob_id_from_lsu, result_from_lsu};
  assign in_valid  = {valid_from_lsu, valid_from_alu};

  // A flush or a low rdy_in stops every queue/broadcast update this cycle.
  assign advance = rdy_in && !clear_in;

  // Per-source candidate: FIFO head first, otherwise the incoming result as a bypass.
  always_comb begin
    full     = '0;
    has_head = '0;
    enq      = '0;
    cand     = '0;
    for (int s = 0; s < 2; s++) begin
      full[s]     = (count[s] == DEPTH_C);
      has_head[s] = (count[s] != '0);
      enq[s]      = in_valid[s] && !full[s] && advance;
      cand[s]     = has_head[s] || enq[s];
      cand_ent[s] = has_head[s] ? mem_q[s][rd_ptr[s]] : in_ent[s];
    end
  end

  // Round-robin pick: on a tie the source that did not win last time is granted.
  always_comb begin
    grant_src = (&cand) ? ~last_grant : cand[1];
    do_grant  = advance && (|cand);
    sel       = grant_src ? 2'b10 : 2'b01;
    grant_ent = cand_ent[grant_src];
    deq       = sel & has_head & {2{do_grant}};
    // A granted bypass goes straight to the bus and never occupies a FIFO slot.
    wr        = enq & ~(sel & ~has_head & {2{do_grant}});
  end

  assign full_to_alu = full[0];
  assign full_to_lsu = full[1];

  // FIFO pointers and occupancy; a flush empties both queues.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in || clear_in) begin
      for (int s = 0; s < 2; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else if (rdy_in) begin
      for (int s = 0; s < 2; s++) begin
        if (wr[s])  wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
        if (deq[s]) rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
        if (wr[s] && !deq[s])      count[s] <= count[s] + CNT_W'(1);
        else if (deq[s] && !wr[s]) count[s] <= count[s] - CNT_W'(1);
      end
    end
  end

  // FIFO storage write; wr is already suppressed by flush and rdy_in low.
  always_ff @(posedge clk_in) begin
    for (int s = 0; s < 2; s++) begin
      if (wr[s]) mem_q[s][wr_ptr[s]] <= in_ent[s];
    end
  end

  // Registered broadcast; data holds when nothing is granted, last_grant survives a flush.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cdb_valid  <= 1'b0;
      cdb_result <= '0;
      cdb_rob_id <= '0;
      cdb_src    <= 1'b0;
      last_grant <= 1'b1;
    end else if (clear_in) begin
      cdb_valid <= 1'b0;
    end else if (rdy_in) begin
      cdb_valid <= do_grant;
      if (do_grant) begin
        {cdb_rob_id, cdb_result} <= grant_ent;
        cdb_src                  <= grant_src;
        last_grant               <= grant_src;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear_in = 1'b0;
  logic        valid_from_alu = 1'b0;
  logic [31:0] result_from_alu = '0;
  logic [4:0]  rob_id_from_alu = '0;
  logic        valid_from_lsu = 1'b0;
  logic [31:0] result_from_lsu = '0;
  logic [4:0]  rob_id_from_lsu = '0;
  logic        full_to_alu, full_to_lsu, cdb_valid, cdb_src;
  logic [31:0] cdb_result;
  logic [4:0]  cdb_rob_id;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .clear_in        (clear_in),
    .valid_from_alu  (valid_from_alu),
    .result_from_alu (result_from_alu),
    .rob_id_from_alu (rob_id_from_alu),
    .valid_from_lsu  (valid_from_lsu),
    .result_from_lsu (result_from_lsu),
    .rob_id_from_lsu (rob_id_from_lsu),
    .full_to_alu     (full_to_alu),
    .full_to_lsu     (full_to_lsu),
    .cdb_valid       (cdb_valid),
    .cdb_result      (cdb_result),
    .cdb_rob_id      (cdb_rob_id),
    .cdb_src         (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // ALU results carry 0x100+id, LSU results 0x200+id.
  function automatic logic [31:0] res_of(input logic src, input int id);
    return src ? 32'h200 + 32'(id) : 32'h100 + 32'(id);
  endfunction

  task automatic drive(input logic va, input int ida, input logic vl, input int idl);
    valid_from_alu  = va;
    rob_id_from_alu = 5'(ida);
    result_from_alu = res_of(1'b0, ida);
    valid_from_lsu  = vl;
    rob_id_from_lsu = 5'(idl);
    result_from_lsu = res_of(1'b1, idl);
  endtask

  task automatic do_reset();
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    clear_in = 1'b0;
    drive(1'b0, 0, 1'b0, 0);
    step();
    rst_in = 1'b0;
  endtask

  // Both sources valid for n edges: ALU ids a0.., LSU ids l0..
  task automatic run_both(input int n, input int a0, input int l0);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, a0 + k, 1'b1, l0 + k);
      step();
    end
    drive(1'b0, 0, 1'b0, 0);
  endtask

  int exp3 [15] = '{1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15, 8};
  int exp5 [4]  = '{22, 26, 23, 27};

  initial begin
    // 1: reset values, single ALU result
    do_reset();
    check("rst_valid", cdb_valid, 0);
    check("rst_result", cdb_result, 0);
    check("rst_id", cdb_rob_id, 0);
    check("rst_src", cdb_src, 0);
    check("rst_full_alu", full_to_alu, 0);
    check("rst_full_lsu", full_to_lsu, 0);
    valid_from_alu = 1'b1; result_from_alu = 32'h11; rob_id_from_alu = 5'd3;
    step();
    valid_from_alu = 1'b0;
    check("t1_valid", cdb_valid, 1);
    check("t1_result", cdb_result, 32'h11);
    check("t1_id", cdb_rob_id, 3);
    check("t1_src", cdb_src, 0);
    step();
    check("t1_valid_drop", cdb_valid, 0);
    check("t1_result_hold", cdb_result, 32'h11);
    check("t1_id_hold", cdb_rob_id, 3);

    // 2: simultaneous ALU/LSU after reset, ALU wins the tie
    do_reset();
    valid_from_alu = 1'b1; result_from_alu = 32'hA; rob_id_from_alu = 5'd1;
    valid_from_lsu = 1'b1; result_from_lsu = 32'hB; rob_id_from_lsu = 5'd2;
    step();
    drive(1'b0, 0, 1'b0, 0);
    check("t2_a_valid", cdb_valid, 1);
    check("t2_a_id", cdb_rob_id, 1);
    check("t2_a_src", cdb_src, 0);
    check("t2_a_result", cdb_result, 32'hA);
    step();
    check("t2_b_valid", cdb_valid, 1);
    check("t2_b_id", cdb_rob_id, 2);
    check("t2_b_src", cdb_src, 1);
    check("t2_b_result", cdb_result, 32'hB);
    step();
    check("t2_idle", cdb_valid, 0);

    // 3: both saturating for 8 cycles, then drain; LSU id 16 arrives while full
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k < 8) drive(1'b1, k + 1, 1'b1, k + 9);
      else       drive(1'b0, 0, 1'b0, 0);
      step();
      if (k < 15) begin
        check($sformatf("t3_valid_%0d", k), cdb_valid, 1);
        check($sformatf("t3_id_%0d", k), cdb_rob_id, exp3[k]);
        check($sformatf("t3_src_%0d", k), cdb_src, k % 2);
        check($sformatf("t3_res_%0d", k), cdb_result, res_of(1'(k % 2), exp3[k]));
      end else begin
        check("t3_drained", cdb_valid, 0);
      end
      check($sformatf("t3_full_lsu_%0d", k), full_to_lsu, k == 6);
      check($sformatf("t3_full_alu_%0d", k), full_to_alu, k == 7);
    end

    // 4: flush with 3 ALU entries queued and a new LSU valid
    do_reset();
    run_both(6, 1, 9);
    check("t4_pre_valid", cdb_valid, 1);
    clear_in = 1'b1;
    drive(1'b0, 0, 1'b1, 31);
    step();
    clear_in = 1'b0;
    drive(1'b0, 0, 1'b0, 0);
    check("t4_clr_valid", cdb_valid, 0);
    check("t4_clr_full_alu", full_to_alu, 0);
    check("t4_clr_full_lsu", full_to_lsu, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t4_empty_%0d", k), cdb_valid, 0);
    end
    drive(1'b1, 7, 1'b0, 0);
    step();
    drive(1'b0, 0, 1'b0, 0);
    check("t4_after_id", cdb_rob_id, 7);
    check("t4_after_src", cdb_src, 0);

    // 5: two ALU entries queued, rdy_in low for 3 cycles with LSU valid
    do_reset();
    run_both(4, 20, 24);
    check("t5_pre_id", cdb_rob_id, 25);
    rdy_in = 1'b0;
    drive(1'b0, 0, 1'b1, 30);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t5_frz_valid_%0d", k), cdb_valid, 1);
      check($sformatf("t5_frz_id_%0d", k), cdb_rob_id, 25);
      check($sformatf("t5_frz_src_%0d", k), cdb_src, 1);
    end
    rdy_in = 1'b1;
    drive(1'b0, 0, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t5_drain_valid_%0d", k), cdb_valid, 1);
      check($sformatf("t5_drain_id_%0d", k), cdb_rob_id, exp5[k]);
      check($sformatf("t5_drain_src_%0d", k), cdb_src, k % 2);
    end
    step();
    check("t5_idle", cdb_valid, 0);

    // 6: asynchronous reset between edges with the LSU FIFO full
    do_reset();
    run_both(7, 1, 9);
    check("t6_pre_valid", cdb_valid, 1);
    check("t6_pre_full", full_to_lsu, 1);
    #3;
    rst_in = 1'b1;
    #1;
    check("t6_async_valid", cdb_valid, 0);
    check("t6_async_result", cdb_result, 0);
    check("t6_async_full_alu", full_to_alu, 0);
    check("t6_async_full_lsu", full_to_lsu, 0);
    step();
    rst_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Arbitrates the single common data bus (CDB) between the two result producers, ALU and LSU, which otherwise both write back in the same cycle. Each source has a small FIFO. A round-robin grant picks one result per cycle and drives it as a registered broadcast to the RS, ROB and register file. On a misprediction flush, all queued results are discarded.

Parameters:
FIFO_DEPTH, 4, entries per source FIFO; power of two, >= 2
ROB_ID_W, 5, ROB tag width
DATA_W, 32, result width

Ports:
clk_in  input  1  clock, rising-edge
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global enable; low freezes the block
clear_in  input  1  flush (branch mispredict); honoured regardless of rdy_in
valid_from_alu  input  1  ALU result present this cycle
result_from_alu  input  DATA_W  ALU result
rob_id_from_alu  input  ROB_ID_W  ALU destination tag
valid_from_lsu  input  1  LSU result present this cycle
result_from_lsu  input  DATA_W  LSU result
rob_id_from_lsu  input  ROB_ID_W  LSU destination tag
full_to_alu  output  1  ALU FIFO full; ALU must not assert valid
full_to_lsu  output  1  LSU FIFO full; LSU must not assert valid
cdb_valid  output  1  broadcast valid, one-cycle pulse per result
cdb_result  output  DATA_W  broadcast value
cdb_rob_id  output  ROB_ID_W  broadcast tag
cdb_src  output  1  0 = ALU, 1 = LSU

Behaviour:
- Reset (asynchronous, rst_in high):
  - cdb_valid=0, cdb_result=0, cdb_rob_id=0, cdb_src=0.
  - Both FIFOs empty; full_to_alu=full_to_lsu=0.
  - last_grant=LSU, so the ALU wins the first tie.
- full_X = (count_X == FIFO_DEPTH). This is combinational from registered state only; there is no path from a valid input to a full output.
- Enqueue: valid_X && !full_X && rdy_in && !clear_in. A valid asserted while full_X is dropped silently; this is a source protocol violation.
- Eligible candidate per source:
  - If the FIFO is non-empty, the candidate is the FIFO head.
  - Else, if an enqueue is happening this cycle, the candidate is the incoming result (bypass).
  - Else there is no candidate.
- Grant:
  - One candidate: grant it.
  - Both candidates: grant the source that is not last_grant.
  - last_grant updates only on an actual grant.
- Granted entry handling:
  - The granted entry is loaded into the cdb_* registers at the edge; cdb_valid=1 in the following cycle.
  - A granted FIFO head is dequeued.
  - A granted bypass input is not written into the FIFO.
  - A non-granted incoming input is written into its FIFO.
- No candidate: cdb_valid<=0; cdb_result, cdb_rob_id and cdb_src hold their last values.
- Latency: 1 cycle from valid_X at an empty, granted source to cdb_valid. Results from each source are broadcast strictly in arrival order.
- Simultaneous enqueue and dequeue on the same FIFO: count is unchanged and pointers advance.
- Pointers wrap modulo FIFO_DEPTH. Count is clog2(FIFO_DEPTH)+1 bits.
- clear_in high at an edge:
  - Both FIFOs are emptied and cdb_valid<=0.
  - Inputs in the same cycle are discarded.
  - last_grant is unchanged.
  - clear_in has priority over rdy_in low.
- rdy_in low (and no clear): all state and outputs hold, inputs are ignored, and full_X reflects the held count.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Throughput: one broadcast per cycle. With both sources saturating, the grant alternates ALU, LSU, ALU, and so on.
- rob_id 0 is passed through unchanged; the block gives tag values no meaning.

Test Plan:
1. Reset, then a single ALU result (0x0000_0011, id 3) → next cycle cdb_valid=1, result=0x11, id=3, src=0. The following cycle cdb_valid=0 and the data holds.
2. ALU (0xA, id 1) and LSU (0xB, id 2) in the same cycle, after reset → broadcasts id 1 (src 0) then id 2 (src 1) in consecutive cycles. The LSU entry is queued for one cycle.
3. Both sources valid every cycle for 8 cycles with ids 1..8 (ALU) and 9..16 (LSU):
   - Broadcasts alternate ALU/LSU, with per-source order preserved.
   - full_to_lsu asserts once the LSU backlog reaches 4.
   - A valid applied while full is dropped.
4. Fill the ALU FIFO with 3 entries, then assert clear_in together with a new LSU valid → next cycle cdb_valid=0, both FIFOs empty, and the LSU result is never broadcast.
5. Queue 2 ALU entries, then hold rdy_in low for 3 cycles while driving LSU valid → outputs frozen, nothing enqueued. After rdy_in returns high, the 2 queued entries drain in order.
6. Assert rst_in asynchronously between clock edges while cdb_valid=1 → cdb_valid drops before the next edge, and both full outputs read 0.
